// File: rtl/fp_norm_round.sv
// fp_norm_round
// Back end of the binary32 adder significand path. Takes the raw 28-bit sum
// {carry, hidden, fraction[22:0], G, R, S} plus the biased exponent. It
// normalizes one bit per cycle, applies round-to-nearest-even, and returns a
// packed binary32 word. Valid/ready handshakes are used on both sides, and
// only one operation is in flight at a time.
module fp_norm_round (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        sign_in,
   input  logic [7:0]  exp_in,
   input  logic [27:0] sum_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        overflow,
   output logic        inexact
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      NORM  = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t      state;
   state_t      state_next;

   // The latched operand. The exponent is one bit wider than the field, so a
   // carry out of 254 shows up as 255 or more and can be flagged as overflow.
   logic        sign_q;
   logic        sign_next;
   logic [8:0]  exp_q;
   logic [8:0]  exp_next;
   logic [27:0] sum_q;
   logic [27:0] sum_next;
   logic        denorm_q;
   logic        denorm_next;

   logic [31:0] result_next;
   logic        overflow_next;
   logic        inexact_next;

   // Rounding-stage intermediates, taken from the normalized operand.
   logic        guard;
   logic        round_bit;
   logic        sticky;
   logic        round_up;
   logic [24:0] mant;
   logic [8:0]  exp_rnd;
   logic [7:0]  exp_field;
   logic        round_ovf;
   logic [31:0] round_result;

   // Handshake outputs come from the state register, so there is no
   // combinational path from the inputs to out_valid.
   assign in_ready  = (state == IDLE) && !rst;
   assign out_valid = (state == DONE);

   // Round-to-nearest-even on the normalized significand. A subnormal uses
   // the rounded hidden bit as its exponent field, so rounding up into the
   // hidden position turns it into the smallest normal number.
   always_comb begin
      guard     = sum_q[2];
      round_bit = sum_q[1];
      sticky    = sum_q[0];
      round_up  = guard & (round_bit | sticky | sum_q[3]);
      mant      = {1'b0, sum_q[26:3]} + {24'd0, round_up};
      exp_rnd   = exp_q + {8'd0, mant[24]};
      exp_field = exp_rnd[7:0];
      if (denorm_q) begin
         exp_field = {7'd0, mant[23]};
      end
      round_ovf    = !denorm_q && (exp_rnd >= 9'd255);
      round_result = {sign_q, exp_field, mant[22:0]};
      if (round_ovf) begin
         round_result = {sign_q, 8'hFF, 23'd0};
      end
   end

   // Next-state and datapath update. Each NORM cycle applies the first
   // matching rule: zero, carry right shift, already normalized, subnormal
   // floor, and otherwise a single left shift.
   always_comb begin
      state_next    = state;
      sign_next     = sign_q;
      exp_next      = exp_q;
      sum_next      = sum_q;
      denorm_next   = denorm_q;
      result_next   = result;
      overflow_next = overflow;
      inexact_next  = inexact;

      case (state)
         IDLE: begin
            if (in_valid) begin
               sign_next   = sign_in;
               exp_next    = {1'b0, exp_in};
               sum_next    = sum_in;
               denorm_next = 1'b0;
               state_next  = NORM;
            end
         end

         NORM: begin
            if (sum_q == 28'd0) begin
               result_next   = {sign_q, 31'd0};
               overflow_next = 1'b0;
               inexact_next  = 1'b0;
               state_next    = DONE;
            end else if (sum_q[27]) begin
               sum_next   = {1'b0, sum_q[27:2], sum_q[1] | sum_q[0]};
               exp_next   = exp_q + 9'd1;
               state_next = ROUND;
            end else if (sum_q[26]) begin
               state_next = ROUND;
            end else if (exp_q == 9'd1) begin
               denorm_next = 1'b1;
               state_next  = ROUND;
            end else begin
               sum_next = {sum_q[26:0], 1'b0};
               exp_next = exp_q - 9'd1;
            end
         end

         ROUND: begin
            result_next   = round_result;
            overflow_next = round_ovf;
            inexact_next  = guard | round_bit | sticky;
            state_next    = DONE;
         end

         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register. Reset from any state returns to IDLE and drops the
   // operand being processed.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Operand and result registers. The result stays stable through DONE
   // until the downstream stage accepts it.
   always_ff @(posedge clk) begin
      if (rst) begin
         sign_q   <= 1'b0;
         exp_q    <= 9'd0;
         sum_q    <= 28'd0;
         denorm_q <= 1'b0;
         result   <= 32'd0;
         overflow <= 1'b0;
         inexact  <= 1'b0;
      end else begin
         sign_q   <= sign_next;
         exp_q    <= exp_next;
         sum_q    <= sum_next;
         denorm_q <= denorm_next;
         result   <= result_next;
         overflow <= overflow_next;
         inexact  <= inexact_next;
      end
   end

endmodule
